// File: rtl/output_unit.sv
// Router output unit: store-and-forward flit FIFO, request/ack handshake to the downstream port, registered flit output.
// Optional OUTPUT_UNIT_REQ_TIMEOUT_EN abandons a stalled request after TIMEOUT cycles and re-requests.
module output_unit #(
    parameter int FLIT_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [FLIT_W-1:0] i_flit,
    output logic              o_full,
    output logic              o_port_status,
    output logic              o_downstream_req,
    input  logic              i_transmit_ack,
    output logic [FLIT_W-1:0] o_flit,
    output logic              o_packet_sent,
    output logic              o_overflow
`ifdef OUTPUT_UNIT_REQ_TIMEOUT_EN
    ,
    output logic              o_timeout
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQUEST = 2'd1;
    localparam logic [1:0] SEND    = 2'd2;

    localparam logic [1:0] TYPE_TAIL = 2'b11;

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic [CW-1:0]     pkt_cnt;
    logic [CW-1:0]     pkt_cnt_next;
    logic [FLIT_W-1:0] head_flit;
    logic              write_en;
    logic              pop;
    logic              tail_write;
    logic              tail_pop;
    logic              timeout_hit;

    assign o_full           = (count == CW'(DEPTH));
    assign write_en         = i_flit[FLIT_W-1] && !o_full;
    assign tail_write       = write_en && (i_flit[FLIT_W-2:FLIT_W-3] == TYPE_TAIL);
    assign head_flit        = mem[rd_ptr];
    // Whole packets are buffered before SEND, so the empty guard only matters on a design error.
    assign pop              = (state == SEND) && (count != '0);
    assign tail_pop         = pop && (head_flit[FLIT_W-2:FLIT_W-3] == TYPE_TAIL);
    assign count_next       = count + CW'(write_en) - CW'(pop);
    assign pkt_cnt_next     = pkt_cnt + CW'(tail_write) - CW'(tail_pop);
    assign o_downstream_req = (state == REQUEST);
    assign o_port_status    = !((count == '0) && (state == IDLE));

`ifdef OUTPUT_UNIT_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] req_cycles;

    assign timeout_hit = (state == REQUEST) && !i_transmit_ack && (req_cycles == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_cycles <= '0;
            o_timeout  <= 1'b0;
        end else begin
            if ((state == REQUEST) && !timeout_hit) begin
                req_cycles <= req_cycles + TW'(1);
            end else begin
                req_cycles <= '0;
            end
            o_timeout <= timeout_hit;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pkt_cnt != '0) begin
                    next_state = REQUEST;
                end
            end
            REQUEST: begin
                if (i_transmit_ack) begin
                    next_state = SEND;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end
            end
            SEND: begin
                if (tail_pop) begin
                    next_state = (pkt_cnt_next != '0) ? REQUEST : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem[wr_ptr] <= i_flit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            pkt_cnt       <= '0;
            o_flit        <= '0;
            o_packet_sent <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            state <= next_state;
            if (write_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count         <= count_next;
            pkt_cnt       <= pkt_cnt_next;
            o_flit        <= pop ? head_flit : '0;
            o_packet_sent <= tail_pop;
            o_overflow    <= i_flit[FLIT_W-1] && o_full;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && (state == SEND)) begin
            assert (count != '0);
        end
    end

endmodule

// File: tb/tb_output_unit.sv
// Directed self-checking bench for output_unit (DEPTH 8, TIMEOUT 4); timeout checks follow OUTPUT_UNIT_REQ_TIMEOUT_EN.
module tb_output_unit;

    localparam int FW = 32;

    logic          clk;
    logic          reset_n;
    logic [FW-1:0] i_flit;
    logic          o_full;
    logic          o_port_status;
    logic          o_downstream_req;
    logic          i_transmit_ack;
    logic [FW-1:0] o_flit;
    logic          o_packet_sent;
    logic          o_overflow;
`ifdef OUTPUT_UNIT_REQ_TIMEOUT_EN
    logic          o_timeout;
`endif

    int checks   = 0;
    int failures = 0;

    logic [FW-1:0] f [9];

    output_unit #(.FLIT_W(FW), .DEPTH(8), .TIMEOUT(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_flit           (i_flit),
        .o_full           (o_full),
        .o_port_status    (o_port_status),
        .o_downstream_req (o_downstream_req),
        .i_transmit_ack   (i_transmit_ack),
        .o_flit           (o_flit),
        .o_packet_sent    (o_packet_sent),
        .o_overflow       (o_overflow)
`ifdef OUTPUT_UNIT_REQ_TIMEOUT_EN
        ,
        .o_timeout        (o_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [28:0] p);
        return {1'b1, t, p};
    endfunction

    // Inputs are held across the next rising edge; outputs are observed 1 time unit after it.
    task automatic applyStimulus(input logic [FW-1:0] flit, input logic ack);
        i_flit         = flit;
        i_transmit_ack = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [FW-1:0] observed, input logic [FW-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        i_flit         = '0;
        i_transmit_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_flit", o_flit, '0);
        checkOutput("rst_req", 32'(o_downstream_req), 0);
        checkOutput("rst_full", 32'(o_full), 0);
        checkOutput("rst_status", 32'(o_port_status), 0);
        checkOutput("rst_sent", 32'(o_packet_sent), 0);
        checkOutput("rst_ovf", 32'(o_overflow), 0);
        reset_n = 1'b1;

        $display("[TB] single packet");
        applyStimulus(mk(2'b01, 29'h11), 1'b0);
        applyStimulus(mk(2'b10, 29'h12), 1'b0);
        applyStimulus(mk(2'b11, 29'h13), 1'b0);
        checkOutput("p1_req_idle", 32'(o_downstream_req), 0);
        checkOutput("p1_status_occ", 32'(o_port_status), 1);
        applyStimulus('0, 1'b0);
        checkOutput("p1_req_up", 32'(o_downstream_req), 1);
        applyStimulus('0, 1'b0);
        checkOutput("p1_req_hold", 32'(o_downstream_req), 1);
        applyStimulus('0, 1'b1);
        checkOutput("p1_req_send", 32'(o_downstream_req), 0);
        checkOutput("p1_flit_pre", o_flit, '0);
        applyStimulus('0, 1'b0);
        checkOutput("p1_head", o_flit, mk(2'b01, 29'h11));
        checkOutput("p1_sent_head", 32'(o_packet_sent), 0);
        applyStimulus('0, 1'b0);
        checkOutput("p1_body", o_flit, mk(2'b10, 29'h12));
        applyStimulus('0, 1'b0);
        checkOutput("p1_tail", o_flit, mk(2'b11, 29'h13));
        checkOutput("p1_sent", 32'(o_packet_sent), 1);
        checkOutput("p1_req_end", 32'(o_downstream_req), 0);
        checkOutput("p1_status_free", 32'(o_port_status), 0);
        applyStimulus('0, 1'b0);
        checkOutput("p1_flit_zero", o_flit, '0);
        checkOutput("p1_sent_low", 32'(o_packet_sent), 0);

        $display("[TB] two packets");
        applyStimulus(mk(2'b01, 29'h21), 1'b0);
        applyStimulus(mk(2'b11, 29'h22), 1'b0);
        applyStimulus(mk(2'b01, 29'h31), 1'b0);
        applyStimulus(mk(2'b10, 29'h32), 1'b0);
        applyStimulus(mk(2'b11, 29'h33), 1'b0);
        checkOutput("p2_req", 32'(o_downstream_req), 1);
        applyStimulus('0, 1'b1);
        applyStimulus('0, 1'b0);
        checkOutput("p2a_head", o_flit, mk(2'b01, 29'h21));
        applyStimulus('0, 1'b0);
        checkOutput("p2a_tail", o_flit, mk(2'b11, 29'h22));
        checkOutput("p2a_sent", 32'(o_packet_sent), 1);
        checkOutput("p2_rereq", 32'(o_downstream_req), 1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus('0, 1'b0);
            checkOutput("p2_wait_req", 32'(o_downstream_req), 1);
            checkOutput("p2_wait_flit", o_flit, '0);
        end
        applyStimulus('0, 1'b1);
        applyStimulus('0, 1'b0);
        checkOutput("p2b_head", o_flit, mk(2'b01, 29'h31));
        applyStimulus('0, 1'b0);
        checkOutput("p2b_body", o_flit, mk(2'b10, 29'h32));
        applyStimulus('0, 1'b0);
        checkOutput("p2b_tail", o_flit, mk(2'b11, 29'h33));
        checkOutput("p2b_sent", 32'(o_packet_sent), 1);
        checkOutput("p2b_req", 32'(o_downstream_req), 0);
        applyStimulus('0, 1'b0);
        checkOutput("p2_status_free", 32'(o_port_status), 0);

        $display("[TB] stray acks");
        applyStimulus('0, 1'b1);
        checkOutput("ack_idle_req", 32'(o_downstream_req), 0);
        checkOutput("ack_idle_flit", o_flit, '0);
        applyStimulus(mk(2'b01, 29'h41), 1'b0);
        applyStimulus(mk(2'b11, 29'h42), 1'b0);
        applyStimulus('0, 1'b0);
        checkOutput("ack_req", 32'(o_downstream_req), 1);
        applyStimulus('0, 1'b1);
        applyStimulus('0, 1'b1);
        checkOutput("ack_send_head", o_flit, mk(2'b01, 29'h41));
        applyStimulus('0, 1'b1);
        checkOutput("ack_send_tail", o_flit, mk(2'b11, 29'h42));
        checkOutput("ack_send_sent", 32'(o_packet_sent), 1);
        applyStimulus('0, 1'b1);
        checkOutput("ack_after_flit", o_flit, '0);
        checkOutput("ack_after_req", 32'(o_downstream_req), 0);
        applyStimulus('0, 1'b0);
        checkOutput("ack_after_flit2", o_flit, '0);

        $display("[TB] overflow");
        f[0] = mk(2'b01, 29'h50);
        for (int i = 1; i < 7; i++) f[i] = mk(2'b10, 29'(32'h50 + i));
        f[7] = mk(2'b11, 29'h57);
        f[8] = mk(2'b01, 29'h58);
        for (int i = 0; i < 7; i++) applyStimulus(f[i], 1'b0);
        checkOutput("ovf_full7", 32'(o_full), 0);
        applyStimulus(f[7], 1'b0);
        checkOutput("ovf_full8", 32'(o_full), 1);
        checkOutput("ovf_none8", 32'(o_overflow), 0);
        applyStimulus(f[8], 1'b0);
        checkOutput("ovf_pulse", 32'(o_overflow), 1);
        checkOutput("ovf_full9", 32'(o_full), 1);
        applyStimulus('0, 1'b0);
        checkOutput("ovf_pulse_end", 32'(o_overflow), 0);
        checkOutput("ovf_req", 32'(o_downstream_req), 1);
        applyStimulus('0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus('0, 1'b0);
            checkOutput($sformatf("ovf_flit%0d", i), o_flit, f[i]);
        end
        checkOutput("ovf_sent", 32'(o_packet_sent), 1);
        checkOutput("ovf_status", 32'(o_port_status), 0);
        applyStimulus('0, 1'b0);
        checkOutput("ovf_no_ninth", o_flit, '0);
        checkOutput("ovf_full_end", 32'(o_full), 0);

        $display("[TB] request timeout");
        applyStimulus(mk(2'b01, 29'h61), 1'b0);
        applyStimulus(mk(2'b11, 29'h62), 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus('0, 1'b0);
            checkOutput($sformatf("tmo_req%0d", i), 32'(o_downstream_req), 1);
        end
`ifdef OUTPUT_UNIT_REQ_TIMEOUT_EN
        applyStimulus('0, 1'b0);
        checkOutput("tmo_req_drop", 32'(o_downstream_req), 0);
        checkOutput("tmo_pulse", 32'(o_timeout), 1);
        applyStimulus('0, 1'b0);
        checkOutput("tmo_rereq", 32'(o_downstream_req), 1);
        checkOutput("tmo_pulse_end", 32'(o_timeout), 0);
`else
        for (int i = 0; i < 4; i++) begin
            applyStimulus('0, 1'b0);
            checkOutput($sformatf("tmo_hold%0d", i), 32'(o_downstream_req), 1);
        end
`endif
        applyStimulus('0, 1'b1);
        applyStimulus('0, 1'b0);
        checkOutput("tmo_head", o_flit, mk(2'b01, 29'h61));
        applyStimulus('0, 1'b0);
        checkOutput("tmo_tail", o_flit, mk(2'b11, 29'h62));
        applyStimulus('0, 1'b0);

        $display("[TB] reset during send");
        applyStimulus(mk(2'b01, 29'h71), 1'b0);
        applyStimulus(mk(2'b10, 29'h72), 1'b0);
        applyStimulus(mk(2'b11, 29'h73), 1'b0);
        applyStimulus('0, 1'b0);
        applyStimulus('0, 1'b1);
        applyStimulus('0, 1'b0);
        checkOutput("rs_head", o_flit, mk(2'b01, 29'h71));
        reset_n = 1'b0;
        #2;
        checkOutput("rs_flit", o_flit, '0);
        checkOutput("rs_req", 32'(o_downstream_req), 0);
        checkOutput("rs_status", 32'(o_port_status), 0);
        checkOutput("rs_full", 32'(o_full), 0);
        checkOutput("rs_sent", 32'(o_packet_sent), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus('0, 1'b0);
            checkOutput($sformatf("rs_after_flit%0d", i), o_flit, '0);
            checkOutput($sformatf("rs_after_req%0d", i), 32'(o_downstream_req), 0);
        end
        applyStimulus('0, 1'b1);
        applyStimulus('0, 1'b0);
        checkOutput("rs_ack_flit", o_flit, '0);
        checkOutput("rs_ack_status", 32'(o_port_status), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
